ram_arbiter: RTL

Two-requester arbiter and access sequencer for the shared 16-bit synchronous block RAM. It sits between the RAM and two masters: port 0 is the core and port 1 is the loader/debug master. It accepts halfword or 32-bit word requests and splits each word into two back-to-back 16-bit RAM accesses. It then returns read data with a one-cycle response pulse to the granted requester.

---
 rtl/ram_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter and halfword sequencer for the shared 16-bit block RAM.
// Optional fixed-priority arbitration via `define RAM_ARB_FIXED_PRIO_EN.
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  word0,
  input  logic                  word1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]           wdata0,
  input  logic [31:0]           wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  output logic [31:0]           rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_wr_en,
  output logic [15:0]           ram_wr_data,
  input  logic [15:0]           ram_rd_data
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_FIN
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               we_q, we_d;
  logic               word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [15:0]        lo_q, lo_d;

  logic                  any_req_c;
  logic                  win_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [IDX_W-1:0]      idx_hi_c;
  logic                  unused_addr_lsb_c;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Port 0 always wins when both request.
  always_comb begin
    win_c = ~req0;
  end
`else
  logic last_q, last_d;

  // Round-robin: on contention the port not granted last wins.
  always_comb begin
    if (req0 && req1) begin
      win_c = ~last_q;
    end else begin
      win_c = req1;
    end
  end
`endif

  assign any_req_c         = req0 | req1;
  assign sel_addr_c        = win_c ? addr1 : addr0;
  assign idx_hi_c          = idx_q + IDX_W'(1);
  assign unused_addr_lsb_c = sel_addr_c[0];
  assign busy              = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next state, request latch and combinational RAM / handshake drives.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    word_d      = word_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    rsp_valid0  = 1'b0;
    rsp_valid1  = 1'b0;
    rsp_rdata   = '0;
    ram_rd_addr = '0;
    ram_wr_addr = '0;
    ram_wr_en   = 1'b0;
    ram_wr_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (any_req_c && !reset) begin
          gnt0    = ~win_c;
          gnt1    = win_c;
          owner_d = win_c;
          we_d    = win_c ? we1 : we0;
          word_d  = win_c ? word1 : word0;
          idx_d   = sel_addr_c[ADDR_WIDTH-1:1];
          wdata_d = win_c ? wdata1 : wdata0;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_d  = win_c;
`endif
          state_d = ST_LO;
        end
      end

      ST_LO: begin
        ram_rd_addr = {1'b0, idx_q};
        ram_wr_addr = {1'b0, idx_q};
        ram_wr_en   = we_q;
        if (we_q) begin
          ram_wr_data = wdata_q[15:0];
        end
        state_d = word_q ? ST_HI : ST_FIN;
      end

      ST_HI: begin
        ram_rd_addr = {1'b0, idx_hi_c};
        ram_wr_addr = {1'b0, idx_hi_c};
        ram_wr_en   = we_q;
        if (we_q) begin
          ram_wr_data = wdata_q[31:16];
        end
        // Registered RAM output now carries the low halfword.
        lo_d    = ram_rd_data;
        state_d = ST_FIN;
      end

      ST_FIN: begin
        rsp_valid0 = ~owner_q;
        rsp_valid1 = owner_q;
        if (!we_q) begin
          rsp_rdata = word_q ? {ram_rd_data, lo_q} : {16'h0000, ram_rd_data};
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
